// File: rtl/sqrl_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream requesters.
// Define SQRL_UART_ARB_HDR_EN to prefix every message with a source-ID byte.
module sqrl_uart_tx_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_new_byte,
    output logic [7:0]           tx_byte,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int IW = $clog2(NUM_REQ);

`ifdef SQRL_UART_ARB_HDR_EN
    typedef enum logic [2:0] {IDLE, HDR, DATA, STRB, DRAIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, DATA, STRB, DRAIN} state_t;
`endif

    state_t        state, state_n;
    logic [IW-1:0] gidx, gidx_n;
    logic [IW-1:0] last_grant, last_grant_n;
    logic          last_flag, last_flag_n;
    logic          strb_n;
    logic [7:0]    byte_n;
    logic          busy_n;

    logic [7:0]    lane_data;
    logic          lane_valid;
    logic          lane_last;
    logic [IW-1:0] pick, pick_hi, pick_lo;
    logic          hi_found;

    assign grant_id = 3'(gidx);

    // Granted lane; other requesters' lanes are never looked at.
    always_comb begin
        lane_data  = 8'h00;
        lane_valid = 1'b0;
        lane_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gidx == IW'(i)) begin
                lane_data  = req_data[8*i +: 8];
                lane_valid = req_valid[i];
                lane_last  = req_last[i];
            end
        end
    end

    // Lowest valid index above last_grant wins, else lowest valid index overall.
    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IW'(i) > last_grant) begin
                    pick_hi  = IW'(i);
                    hi_found = 1'b1;
                end else begin
                    pick_lo = IW'(i);
                end
            end
        end
        pick = hi_found ? pick_hi : pick_lo;
    end

    always_comb begin
        state_n      = state;
        gidx_n       = gidx;
        last_grant_n = last_grant;
        last_flag_n  = last_flag;
        strb_n       = 1'b0;
        byte_n       = tx_byte;
        busy_n       = busy;
        req_ready    = '0;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    gidx_n       = pick;
                    last_grant_n = pick;
                    busy_n       = 1'b1;
`ifdef SQRL_UART_ARB_HDR_EN
                    state_n      = HDR;
`else
                    state_n      = DATA;
`endif
                end
            end
`ifdef SQRL_UART_ARB_HDR_EN
            HDR: begin
                if (tx_ready) begin
                    byte_n      = 8'hA0 | 8'(gidx);
                    strb_n      = 1'b1;
                    last_flag_n = 1'b0;
                    state_n     = STRB;
                end
            end
`endif
            DATA: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gidx == IW'(i)) begin
                        req_ready[i] = tx_ready;
                    end
                end
                if (tx_ready && lane_valid) begin
                    byte_n      = lane_data;
                    strb_n      = 1'b1;
                    last_flag_n = lane_last;
                    state_n     = STRB;
                end
            end
            STRB: begin
                state_n = DRAIN;
            end
            // tx_ready is only trusted here, one cycle after the strobe.
            DRAIN: begin
                if (tx_ready) begin
                    if (last_flag) begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gidx        <= '0;
            last_grant  <= IW'(NUM_REQ - 1);
            last_flag   <= 1'b0;
            tx_new_byte <= 1'b0;
            tx_byte     <= 8'h00;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            gidx        <= gidx_n;
            last_grant  <= last_grant_n;
            last_flag   <= last_flag_n;
            tx_new_byte <= strb_n;
            tx_byte     <= byte_n;
            busy        <= busy_n;
        end
    end

endmodule
